// File: rtl/typing_session_ctrl.sv
// typing_session_ctrl
//   Typing-round controller between the PS/2 receiver and the sequence
//   parser / draw engine. Filters make/break/extended bytes, selects a level
//   from number keys, runs a timed round with per-key compare and an optional
//   miss limit, and auto-advances the level when a round passes.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   ps2_data/ps2_valid  received PS/2 byte and its one-cycle strobe
//   start               level-sensitive start request
//   num_char            characters in the current sequence (sampled in NEW_LEVEL)
//   exp_code            expected scan code from the parser
//   draw_done           draw engine finished
//   next_char           pulse, parser advances to the next character
//   new_level           pulse, parser loads a new sequence
//   draw_req            pulse, draw engine starts
//   level               current level 1..NUM_LEVELS, 0 = none selected
//   correct_count, total_count, miss_count   round counters (saturating)
//   time_left           remaining tick budget
//   pass                pulse on round pass
//   fail                sticky round failure
//   overrun             sticky key overrun
//   state               FSM state for the debug display
//
// state          | meaning
// ---------------+-------------------------------------------------------
// 0  SELECT      | waiting for a number key to pick the level
// 1  WAIT_START  | level chosen, waiting for start, keys discarded
// 2  NEW_LEVEL   | clear counters, latch num_char, load budget
// 3  DRAW        | request a redraw
// 4  DRAW_WAIT   | waiting for draw_done
// 5  IDLE        | waiting for a key, timeout check
// 6  COMPARE     | compare consumed key against exp_code
// 7  MATCH       | advance parser, count correct key
// 8  CHECK       | round complete?
// 9  PASS        | pass pulse, level up
// 10 FAIL        | sticky fail until start
module typing_session_ctrl #(
  parameter int MAX_CHARS      = 32,
  parameter int NUM_LEVELS     = 3,
  parameter int TICK_DIV       = 50000,
  parameter int TICKS_PER_CHAR = 3000,
  parameter int TMR_W          = 20,
  parameter int MAX_MISSES     = 0,
  localparam int CNT_W         = $clog2(MAX_CHARS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  input  logic             start,
  input  logic [CNT_W-1:0] num_char,
  input  logic [7:0]       exp_code,
  input  logic             draw_done,
  output logic             next_char,
  output logic             new_level,
  output logic             draw_req,
  output logic [3:0]       level,
  output logic [CNT_W-1:0] correct_count,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [TMR_W-1:0] time_left,
  output logic             pass,
  output logic             fail,
  output logic             overrun,
  output logic [3:0]       state
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CHARS);
  localparam logic [CNT_W-1:0] MISS_LIM = CNT_W'(MAX_MISSES);
  localparam logic [3:0]       LVL_MAX  = 4'(NUM_LEVELS);

  typedef enum logic [3:0] {
    ST_SELECT     = 4'd0,
    ST_WAIT_START = 4'd1,
    ST_NEW_LEVEL  = 4'd2,
    ST_DRAW       = 4'd3,
    ST_DRAW_WAIT  = 4'd4,
    ST_IDLE       = 4'd5,
    ST_COMPARE    = 4'd6,
    ST_MATCH      = 4'd7,
    ST_CHECK      = 4'd8,
    ST_PASS       = 4'd9,
    ST_FAIL       = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       level_q, level_d;
  logic [CNT_W-1:0] nchar_q, nchar_d;
  logic [CNT_W-1:0] correct_q, correct_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [TMR_W-1:0] time_left_q, time_left_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tmr_run_q, tmr_run_d;
  logic [7:0]       cur_code_q, cur_code_d;
  logic             fail_q, fail_d;
  logic             overrun_q, overrun_d;
  logic             next_char_q, next_char_d;
  logic             new_level_q, new_level_d;
  logic             draw_req_q, draw_req_d;
  logic             pass_q, pass_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic             pend_v_q, pend_v_d;
  logic [7:0]       pend_code_q, pend_code_d;

  logic             pend_take;
  logic             pend_drop;
  logic [3:0]       sel_level;

  function automatic logic [3:0] key_to_level(input logic [7:0] code);
    case (code)
      8'h16:   key_to_level = 4'd1;
      8'h1E:   key_to_level = 4'd2;
      8'h26:   key_to_level = 4'd3;
      8'h25:   key_to_level = 4'd4;
      8'h2E:   key_to_level = 4'd5;
      8'h36:   key_to_level = 4'd6;
      8'h3D:   key_to_level = 4'd7;
      8'h3E:   key_to_level = 4'd8;
      8'h46:   key_to_level = 4'd9;
      default: key_to_level = 4'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Round FSM and timer
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    nchar_d     = nchar_q;
    correct_d   = correct_q;
    total_d     = total_q;
    miss_d      = miss_q;
    time_left_d = time_left_q;
    presc_d     = presc_q;
    tmr_run_d   = tmr_run_q;
    cur_code_d  = cur_code_q;
    fail_d      = fail_q;
    next_char_d = 1'b0;
    new_level_d = 1'b0;
    draw_req_d  = 1'b0;
    pass_d      = 1'b0;
    pend_take   = 1'b0;
    pend_drop   = 1'b0;
    sel_level   = key_to_level(pend_code_q);

    // The budget only drains once the first key of the round has arrived,
    // and only while the round is actively being typed.
    if (tmr_run_q && (state_q inside {ST_IDLE, ST_COMPARE, ST_MATCH, ST_CHECK})) begin
      if (presc_q == PRE_MAX) begin
        presc_d = '0;
        if (time_left_q != '0) time_left_d = time_left_q - TMR_W'(1);
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end

    case (state_q)
      ST_SELECT: begin
        if (pend_v_q) begin
          pend_take = 1'b1;
          if (sel_level != 4'd0 && sel_level <= LVL_MAX) begin
            level_d = sel_level;
            state_d = ST_WAIT_START;
          end
        end
      end
      ST_WAIT_START: begin
        pend_drop = 1'b1;
        if (start) state_d = ST_NEW_LEVEL;
      end
      ST_NEW_LEVEL: begin
        new_level_d = 1'b1;
        correct_d   = '0;
        total_d     = '0;
        miss_d      = '0;
        nchar_d     = num_char;
        time_left_d = TMR_W'((64'(num_char) * 64'(TICKS_PER_CHAR)) >> (level_q - 4'd1));
        presc_d     = '0;
        tmr_run_d   = 1'b0;
        state_d     = ST_DRAW;
      end
      ST_DRAW: begin
        draw_req_d = 1'b1;
        state_d    = ST_DRAW_WAIT;
      end
      ST_DRAW_WAIT: begin
        if (draw_done) state_d = (nchar_q == '0) ? ST_PASS : ST_IDLE;
      end
      ST_IDLE: begin
        // Timeout wins over a key that arrives in the same cycle.
        if (tmr_run_q && time_left_q == '0) begin
          state_d = ST_FAIL;
        end else if (pend_v_q) begin
          pend_take  = 1'b1;
          cur_code_d = pend_code_q;
          total_d    = sat_inc(total_q);
          tmr_run_d  = 1'b1;
          state_d    = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (cur_code_q == exp_code) begin
          state_d = ST_MATCH;
        end else begin
          miss_d = sat_inc(miss_q);
          if (MAX_MISSES != 0 && miss_d == MISS_LIM) state_d = ST_FAIL;
          else                                       state_d = ST_IDLE;
        end
      end
      ST_MATCH: begin
        next_char_d = 1'b1;
        correct_d   = sat_inc(correct_q);
        state_d     = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = (correct_q == nchar_q) ? ST_PASS : ST_IDLE;
      end
      ST_PASS: begin
        pass_d    = 1'b1;
        tmr_run_d = 1'b0;
        if (level_q < LVL_MAX) level_d = level_q + 4'd1;
        state_d   = ST_WAIT_START;
      end
      ST_FAIL: begin
        tmr_run_d = 1'b0;
        if (start) begin
          fail_d  = 1'b0;
          level_d = 4'd0;
          state_d = ST_SELECT;
        end
      end
      default: state_d = ST_SELECT;
    endcase

    if (state_d == ST_FAIL) fail_d = 1'b1;
  end

  // PS/2 byte filter and single-entry pending register
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    pend_v_d    = pend_v_q;
    pend_code_d = pend_code_q;
    overrun_d   = overrun_q;

    if (pend_take || pend_drop) pend_v_d = 1'b0;

    if (ps2_valid) begin
      if (ps2_data == 8'hF0) begin
        brk_d = 1'b1;
      end else if (ps2_data == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        // A code still waiting (and not being taken this cycle) is lost.
        if (pend_v_q && !pend_take && !pend_drop) overrun_d = 1'b1;
        pend_code_d = ps2_data;
        pend_v_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SELECT;
      level_q     <= '0;
      nchar_q     <= '0;
      correct_q   <= '0;
      total_q     <= '0;
      miss_q      <= '0;
      time_left_q <= '0;
      presc_q     <= '0;
      tmr_run_q   <= 1'b0;
      cur_code_q  <= '0;
      fail_q      <= 1'b0;
      overrun_q   <= 1'b0;
      next_char_q <= 1'b0;
      new_level_q <= 1'b0;
      draw_req_q  <= 1'b0;
      pass_q      <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_code_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      nchar_q     <= nchar_d;
      correct_q   <= correct_d;
      total_q     <= total_d;
      miss_q      <= miss_d;
      time_left_q <= time_left_d;
      presc_q     <= presc_d;
      tmr_run_q   <= tmr_run_d;
      cur_code_q  <= cur_code_d;
      fail_q      <= fail_d;
      overrun_q   <= overrun_d;
      next_char_q <= next_char_d;
      new_level_q <= new_level_d;
      draw_req_q  <= draw_req_d;
      pass_q      <= pass_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      pend_v_q    <= pend_v_d;
      pend_code_q <= pend_code_d;
    end
  end

  assign next_char     = next_char_q;
  assign new_level     = new_level_q;
  assign draw_req      = draw_req_q;
  assign level         = level_q;
  assign correct_count = correct_q;
  assign total_count   = total_q;
  assign miss_count    = miss_q;
  assign time_left     = time_left_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign overrun       = overrun_q;
  assign state         = state_q;

endmodule
